// File: rtl/ram_rw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_rw_ctrl_if
// Brief    : Bundles the key pulse, single-port RAM bus and display outputs
//            that the RAM read/write sequencer drives or observes.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_rw_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              key_flag;     // 1-cycle debounced key press
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rd_data;  // registered RAM q, valid 1 clk after rd_en
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [1:0]        mode;

    // Sequencer side
    modport master (
        input  key_flag,
        input  ram_rd_data,
        output ram_addr,
        output ram_wr_en,
        output ram_wr_data,
        output ram_rd_en,
        output disp_data,
        output disp_valid,
        output mode
    );

    // Environment side: key debouncer, RAM and display driver
    modport slave (
        output key_flag,
        output ram_rd_data,
        input  ram_addr,
        input  ram_wr_en,
        input  ram_wr_data,
        input  ram_rd_en,
        input  disp_data,
        input  disp_valid,
        input  mode
    );
endinterface
`default_nettype wire

// File: rtl/ram_rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_rw_ctrl
// Brief    : Fills a single-port RAM with its own addresses once after reset,
//            then reads it back endlessly, holding each address for RD_HOLD
//            clocks and handing every read word to the display. A key press
//            toggles between reading and a frozen pause.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rw_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_HOLD = 25_000_000
) (
    input  wire logic     sys_clk,
    input  wire logic     rst,
    ram_rw_ctrl_if.master bus
);

    // Hold counter only needs to reach RD_HOLD-1
    localparam int                HOLD_W    = (RD_HOLD > 2) ? $clog2(RD_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RD_HOLD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    // Encoding doubles as the externally visible mode value
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cap_q, cap_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;

    // Sequencer next-state logic and RAM strobes decoded from current state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                // Single settling clock after reset, key presses ignored
                state_d = ST_WRITE;
                addr_d  = '0;
                hold_d  = '0;
            end

            ST_WRITE: begin
                // Each location is written with its own address
                wr_en   = 1'b1;
                wr_data = DATA_W'(addr_q);
                addr_d  = addr_q + 1'b1;
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    hold_d  = '0;
                end
            end

            ST_READ: begin
                // One read at the start of each hold window
                rd_en = (hold_q == '0);
                if (bus.key_flag) begin
                    // Pause takes priority over the end-of-hold advance
                    state_d = ST_PAUSE;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    addr_d = addr_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            ST_PAUSE: begin
                // Address and hold position stay frozen until the next key
                if (bus.key_flag) begin
                    state_d = ST_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read capture: the cycle after rd_en the RAM q is latched for display
    always_comb begin
        cap_d        = rd_en;
        disp_valid_d = cap_q;
        disp_data_d  = cap_q ? bus.ram_rd_data : disp_data_q;
    end

    // State and datapath registers, reset returns everything to IDLE defaults
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            hold_q       <= '0;
            cap_q        <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_q       <= hold_d;
            cap_q        <= cap_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign bus.ram_addr    = addr_q;
    assign bus.ram_wr_en   = wr_en;
    assign bus.ram_wr_data = wr_data;
    assign bus.ram_rd_en   = rd_en;
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.mode        = state_q;

`ifndef SYNTHESIS
    // Parameter legality and strobe exclusivity checks for simulation
    always_ff @(posedge sys_clk) begin
        a_rd_hold_min: assert (RD_HOLD >= 2)
            else $error("RD_HOLD must be at least 2");
        a_wr_rd_excl: assert (!(wr_en && rd_en))
            else $error("RAM write and read enables asserted together");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rw_ctrl
// Brief    : Scoreboard bench for ram_rw_ctrl. The driver advances a
//            transaction-level model (write index, count of active read
//            clocks) and queues the expected writes, reads and display
//            updates; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rw_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int RH    = 4;
    localparam int DEPTH = 1 << AW;

    localparam int M_IDLE  = 0;
    localparam int M_WRITE = 1;
    localparam int M_READ  = 2;
    localparam int M_PAUSE = 3;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    typedef struct {
        int cyc;
        int mode;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_flag = 1'b0;

    ram_rw_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_rw_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_HOLD (RH)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with registered read data
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
        if (bus.ram_rd_en) ram_q <= mem[bus.ram_addr];
    end
    assign bus.ram_rd_data = ram_q;
    assign bus.key_flag    = key_flag;

    // Scoreboard queues
    cyc_t mode_q[$];
    ev_t  wr_q[$];
    ev_t  rd_q[$];
    ev_t  dv_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (describes the cycle about to be driven)
    int m_state = M_IDLE;
    int m_wi    = 0;
    int m_act   = 0;   // READ clocks without a key press since READ began
    int ncyc    = 0;
    int ref_mem [DEPTH];

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Drive one clock of inputs and queue what the DUT must show in it
    task automatic step(input bit r, input bit k);
        cyc_t c;
        ev_t  ev;
        int   a;
        @(posedge clk);
        #1;
        rst      = r;
        key_flag = k;
        c.cyc  = ncyc;
        c.mode = m_state;
        mode_q.push_back(c);
        if (m_state == M_WRITE) begin
            ev.cyc  = ncyc;
            ev.addr = m_wi;
            ev.data = m_wi % 256;
            ref_mem[m_wi] = ev.data;
            wr_q.push_back(ev);
        end else if (m_state == M_READ && (m_act % RH) == 0) begin
            a       = (m_act / RH) % DEPTH;
            ev.cyc  = ncyc;
            ev.addr = a;
            ev.data = ref_mem[a];
            rd_q.push_back(ev);
            ev.cyc  = ncyc + 2;
            dv_q.push_back(ev);
        end
        // Reset kills any display update still in flight
        if (r) begin
            while (dv_q.size() > 0 && dv_q[$].cyc > ncyc) void'(dv_q.pop_back());
        end
        if (r) begin
            m_state = M_IDLE;
            m_wi    = 0;
            m_act   = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    m_state = M_WRITE;
                    m_wi    = 0;
                end
                M_WRITE: begin
                    m_wi++;
                    if (m_wi == DEPTH) begin
                        m_state = M_READ;
                        m_act   = 0;
                    end
                end
                M_READ:  if (k) m_state = M_PAUSE; else m_act++;
                M_PAUSE: if (k) m_state = M_READ;
                default: m_state = M_IDLE;
            endcase
        end
        ncyc++;
    endtask

    // Run free until the model sits at a given active-read count, then press key
    task automatic key_at_act(input int target);
        for (int g = 0; g < 500 && !(m_state == M_READ && m_act == target); g++)
            step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    // Monitor: pop the per-cycle expectation and any event the DUT presents
    int   now      = -1;
    int   held     = 0;
    cyc_t mc;
    ev_t  me;
    always @(negedge clk) begin
        if (mode_q.size() > 0) begin
            mc  = mode_q.pop_front();
            now = mc.cyc;
            chk("mode", now, int'(bus.mode), mc.mode);
            if (mc.mode == M_IDLE) held = 0;

            while (wr_q.size() > 0 && wr_q[0].cyc < now) begin
                me = wr_q.pop_front();
                chk("wr_missed", me.cyc, 0, 1);
            end
            if (bus.ram_wr_en) begin
                if (wr_q.size() > 0 && wr_q[0].cyc == now) begin
                    me = wr_q.pop_front();
                    chk("wr_addr", now, int'(bus.ram_addr), me.addr);
                    chk("wr_data", now, int'(bus.ram_wr_data), me.data);
                end else begin
                    chk("wr_unexpected", now, 1, 0);
                end
            end else begin
                chk("wr_data_zero", now, int'(bus.ram_wr_data), 0);
            end

            while (rd_q.size() > 0 && rd_q[0].cyc < now) begin
                me = rd_q.pop_front();
                chk("rd_missed", me.cyc, 0, 1);
            end
            if (bus.ram_rd_en) begin
                if (rd_q.size() > 0 && rd_q[0].cyc == now) begin
                    me = rd_q.pop_front();
                    chk("rd_addr", now, int'(bus.ram_addr), me.addr);
                end else begin
                    chk("rd_unexpected", now, 1, 0);
                end
            end

            while (dv_q.size() > 0 && dv_q[0].cyc < now) begin
                me = dv_q.pop_front();
                chk("disp_missed", me.cyc, 0, 1);
            end
            if (bus.disp_valid) begin
                if (dv_q.size() > 0 && dv_q[0].cyc == now) begin
                    me   = dv_q.pop_front();
                    held = me.data;
                end else begin
                    chk("disp_unexpected", now, 1, 0);
                end
            end
            chk("disp_data", now, int'(bus.disp_data), held);
            chk("wr_rd_excl", now, int'(bus.ram_wr_en && bus.ram_rd_en), 0);
        end
    end

    int stale;
    initial begin
        // Reset held for two clocks
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Pause at hold 1 of address 3, resume later
        key_at_act(3 * RH + 1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Pause on the last hold clock of address 5: pause must win
        key_at_act(5 * RH + RH - 1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Reset in the middle of reading address 6
        for (int g = 0; g < 500 && !(m_state == M_READ && m_act == 6 * RH + 2); g++)
            step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Key presses during IDLE and the rewrite must be ignored
        step(1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, (i % 2) == 0);

        // Free-running read through the address wrap
        repeat (DEPTH * RH + 12) step(1'b0, 1'b0);

        // Randomised keys and occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit r, k;
            r = ($urandom_range(0, 299) == 0);
            if (m_state == M_READ && (m_act % RH) == 0)
                k = 1'b0;
            else
                k = ($urandom_range(0, 9) == 0);
            step(r, k);
        end

        repeat (4) step(1'b0, 1'b0);
        @(negedge clk);
        #1;

        // Anything due by now that never appeared counts as missed
        stale = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc <= now) stale++;
        foreach (rd_q[i]) if (rd_q[i].cyc <= now) stale++;
        foreach (dv_q[i]) if (dv_q[i].cyc <= now) stale++;
        chk("queues_drained", now, stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
